pixel_write_sink: RTL and testbench

- Receiving end of the drawing-source pixel-write stream (x, y, colour, write strobe). The screen eraser and the sprite and lane drawers all emit this stream.
- Bounds-checks each pixel and buffers it in a small FIFO.
- Drains the FIFO into the framebuffer write port as linear address y*XSCREEN+x.
- Reports overflow, clip and write statistics for debug LEDs/HEX.

---
 rtl/pixel_write_sink_if.sv | 25 ++
 rtl/pixel_write_sink.sv | 153 +++++++++++++++
 tb/tb_pixel_write_sink.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_sink_if.sv
// Pixel-write stream (x, y, colour, strobe) plus the framebuffer write port it drains into.
// The master side is the drawing environment; the slave side is the sink.
interface pixel_write_sink_if #(
  parameter int unsigned AW = 19
);
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic [8:0]    pix_color;
  logic          pix_write;
  logic          pix_ready;
  logic          mem_busy;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_data;
  logic          mem_we;

  modport master (
    output pix_x, pix_y, pix_color, pix_write, mem_busy,
    input  pix_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  pix_x, pix_y, pix_color, pix_write, mem_busy,
    output pix_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/pixel_write_sink.sv
// Clips, buffers and drains pixels to the framebuffer as y*XSCREEN+x; push to mem_we is 2 cycles.
// mem_busy stalls the drain; in-range pixels arriving while full are dropped and flag overflow.
module pixel_write_sink #(
  parameter int unsigned XSCREEN = 640,
  parameter int unsigned YSCREEN = 480,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 19
) (
  input  logic               Clock,
  input  logic               Resetn,
  pixel_write_sink_if.slave  bus,
  input  logic               stats_clear,
  output logic               overflow,
  output logic [15:0]        clip_count,
  output logic [AW-1:0]      wr_count,
  output logic               sink_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] color;
  } pix_t;

  typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;

  pix_t          fifo_mem [DEPTH];
  pix_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  state_t        state;
  state_t        state_nxt;

  logic          in_range;
  logic          full;
  logic          push;
  logic          drop;
  logic          clip;
  logic          pop;

  logic [AW-1:0] mem_addr_q;
  logic [8:0]    mem_data_q;
  logic          mem_we_q;

  // Capacity is judged on the start-of-cycle count, so a same-cycle pop never frees a slot for the push.
  assign in_range = (32'(bus.pix_x) < XSCREEN) && (32'(bus.pix_y) < YSCREEN);
  assign full     = (count == CW'(DEPTH));
  assign push     = bus.pix_write && in_range && !full;
  assign drop     = bus.pix_write && in_range && full;
  assign clip     = bus.pix_write && !in_range;
  assign pop      = (count != '0) && !bus.mem_busy;
  assign head     = fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{x: bus.pix_x, y: bus.pix_y, color: bus.pix_color};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      count    <= count_nxt;
      mem_we_q <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        mem_addr_q <= AW'(head.y) * AW'(XSCREEN) + AW'(head.x);
        mem_data_q <= head.color;
      end
    end
  end

  // A clear wins over any increment or overflow set landing in the same cycle.
  always_ff @(posedge Clock) begin
    if (!Resetn || stats_clear) begin
      overflow   <= 1'b0;
      clip_count <= '0;
      wr_count   <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (clip && (clip_count != 16'hFFFF)) begin
        clip_count <= clip_count + 16'd1;
      end
      if (mem_we_q) begin
        wr_count <= wr_count + AW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (push) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (count_nxt == '0) begin
          state_nxt = IDLE;
        end else if (bus.mem_busy) begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (!bus.mem_busy) begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pix_ready = !full;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_we    = mem_we_q;
  assign sink_busy     = (state != IDLE) || mem_we_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink: hand-computed addresses, a write scoreboard and stats checks.
module tb_pixel_write_sink;
  localparam int AW = 19;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          stats_clear = 1'b0;
  logic          overflow;
  logic [15:0]   clip_count;
  logic [AW-1:0] wr_count;
  logic          sink_busy;

  int            n_checks = 0;
  int            n_fail = 0;
  int            wr_seen = 0;
  int            wr_base = 0;
  logic [27:0]   exp_q[$];
  logic [27:0]   mon_exp;

  pixel_write_sink_if #(.AW(AW)) bus ();

  pixel_write_sink #(
    .XSCREEN(640), .YSCREEN(480), .DEPTH(4), .AW(AW)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .bus(bus),
    .stats_clear(stats_clear),
    .overflow(overflow),
    .clip_count(clip_count),
    .wr_count(wr_count),
    .sink_busy(sink_busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the oldest pixel the bench expects to land.
  always @(negedge Clock) begin
    if (bus.mem_we) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(bus.mem_we), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_addr_data", {4'd0, bus.mem_data, bus.mem_addr}, {4'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int c, input logic wr);
    bus.pix_x     = 10'(x);
    bus.pix_y     = 9'(y);
    bus.pix_color = 9'(c);
    bus.pix_write = wr;
  endtask

  task automatic push_px(input int x, input int y, input int c, input logic lands);
    drive(x, y, c, 1'b1);
    if (lands) exp_q.push_back({9'(c), 19'(y * 640 + x)});
    tick();
    bus.pix_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && sink_busy; i++) tick();
    check(tag, 32'(sink_busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 1'b0);
    bus.mem_busy = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;

    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_sink_busy", 32'(sink_busy), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);

    // Single pixel: write appears two cycles after the push cycle.
    push_px(10, 2, 9'h1FF, 1'b1);
    check("single_we_n1", 32'(bus.mem_we), 32'd0);
    check("single_busy_n1", 32'(sink_busy), 32'd1);
    tick();
    check("single_we_n2", 32'(bus.mem_we), 32'd1);
    check("single_addr", 32'(bus.mem_addr), 32'd1290);
    check("single_data", 32'(bus.mem_data), 32'h1FF);
    tick();
    check("single_we_n3", 32'(bus.mem_we), 32'd0);
    check("single_busy_n3", 32'(sink_busy), 32'd0);
    check("single_wr_count", 32'(wr_count), 32'd1);

    // Eraser-style stream on row 479: (130,479) lands at 306690.
    wr_base = wr_seen;
    for (int i = 0; i < 300; i++) push_px(i, 479, i & 9'h1FF, 1'b1);
    wait_idle("stream_drain");
    check("stream_writes", 32'(wr_seen - wr_base), 32'd300);
    check("stream_overflow", 32'(overflow), 32'd0);
    check("stream_wr_count", 32'(wr_count), 32'd301);

    // Backpressure: only the first four pixels fit.
    bus.mem_busy = 1'b1;
    wr_base = wr_seen;
    for (int i = 0; i < 6; i++) begin
      push_px(100 + i, 7, 9'h040 + i, i < 4);
      check("bp_pix_ready", 32'(bus.pix_ready), (i + 1 < 4) ? 32'd1 : 32'd0);
    end
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_no_write", 32'(wr_seen - wr_base), 32'd0);
    check("bp_busy", 32'(sink_busy), 32'd1);
    bus.mem_busy = 1'b0;
    wait_idle("bp_drain");
    check("bp_writes", 32'(wr_seen - wr_base), 32'd4);
    check("bp_wr_count", 32'(wr_count), 32'd305);

    // Clear stats, then clipping.
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_wr_count", 32'(wr_count), 32'd0);
    wr_base = wr_seen;
    push_px(640, 0, 9'h011, 1'b0);
    push_px(0, 480, 9'h022, 1'b0);
    push_px(639, 479, 9'h033, 1'b1);
    wait_idle("clip_drain");
    check("clip_count", 32'(clip_count), 32'd2);
    check("clip_writes", 32'(wr_seen - wr_base), 32'd1);

    // Saturation: 2 + 65533 reaches FFFF, then it must stick.
    for (int i = 0; i < 65533; i++) push_px(1023, 0, 0, 1'b0);
    check("sat_reach", 32'(clip_count), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) push_px(0, 511, 0, 1'b0);
    check("sat_hold", 32'(clip_count), 32'h0000FFFF);

    stats_clear = 1'b1;
    drive(700, 0, 0, 1'b1);
    tick();
    stats_clear = 1'b0;
    bus.pix_write = 1'b0;
    check("clr_clip_prio", 32'(clip_count), 32'd0);
    check("clr_overflow2", 32'(overflow), 32'd0);
    check("clr_wr_count2", 32'(wr_count), 32'd0);

    // Reset mid-operation discards the buffered pixels.
    push_px(5, 5, 9'h0AA, 1'b1);
    wait_idle("pre_rst_drain");
    check("pre_rst_wr_count", 32'(wr_count), 32'd1);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_px(20 + i, 9, 9'h155, 1'b0);
    check("pre_rst_busy", 32'(sink_busy), 32'd1);
    wr_base = wr_seen;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    bus.mem_busy = 1'b0;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_data", 32'(bus.mem_data), 32'd0);
    check("mid_rst_wr_count", 32'(wr_count), 32'd0);
    check("mid_rst_busy", 32'(sink_busy), 32'd0);
    check("mid_rst_ready", 32'(bus.pix_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_writes", 32'(wr_seen - wr_base), 32'd0);
    check("post_rst_busy", 32'(sink_busy), 32'd0);
    check("post_rst_wr_count", 32'(wr_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
